// File: rtl/leaf_user2bft_packetizer.sv
// leaf_user2bft_packetizer
//   Accepts 32-bit user words over an ap_vld/ap_ack handshake, buffers them in
//   a small FIFO and emits credit-limited packets toward the BFT leaf port.
//   Each packet carries the destination leaf/port, a wrapping receiver BRAM
//   address and the payload word.
//
//   Handshakes:
//     user side : a word transfers in every cycle where din_vld & din_ack.
//                 din_ack is combinational and never depends on a pop in the
//                 same cycle, so a full FIFO always costs one bubble.
//     BFT side  : a packet transfers in every cycle where pkt_out[48] &
//                 pkt_ready. While valid & ~ready the packet is held bit-stable.
//
//   Ports:
//     clk_user        sole clock
//     reset           asynchronous, active-high reset
//     din_user        user payload word
//     din_vld/din_ack user handshake
//     dest_leaf       destination leaf, sampled when a packet is issued
//     dest_port       destination port, sampled when a packet is issued
//     credit_ret_vld  credit return strobe
//     credit_ret_num  number of receiver slots returned
//     pkt_out         {valid, leaf, port, addr, payload}
//     pkt_ready       BFT side consumes pkt_out
//     credit_err      sticky flag: returned credits exceeded the receiver size
module leaf_user2bft_packetizer #(
  parameter int PACKET_BITS     = 49,
  parameter int PAYLOAD_BITS    = 32,
  parameter int NUM_LEAF_BITS   = 5,
  parameter int NUM_PORT_BITS   = 4,
  parameter int NUM_ADDR_BITS   = 7,
  parameter int FIFO_DEPTH_BITS = 2
) (
  input  logic                     clk_user,
  input  logic                     reset,
  input  logic [PAYLOAD_BITS-1:0]  din_user,
  input  logic                     din_vld,
  output logic                     din_ack,
  input  logic [NUM_LEAF_BITS-1:0] dest_leaf,
  input  logic [NUM_PORT_BITS-1:0] dest_port,
  input  logic                     credit_ret_vld,
  input  logic [NUM_ADDR_BITS:0]   credit_ret_num,
  output logic [PACKET_BITS-1:0]   pkt_out,
  input  logic                     pkt_ready,
  output logic                     credit_err
);

  localparam int FIFO_DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int CREDIT_MAX = 1 << NUM_ADDR_BITS;
  // One extra bit over credit_cnt holds the pre-saturation sum (max 128+255).
  localparam int CW = NUM_ADDR_BITS + 2;

  logic [PAYLOAD_BITS-1:0]    fifo_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr;
  logic [FIFO_DEPTH_BITS-1:0] rd_ptr;
  logic [FIFO_DEPTH_BITS:0]   fifo_count;
  logic                       fifo_full;
  logic                       fifo_nonempty;

  logic [NUM_ADDR_BITS-1:0]   addr_cnt;
  logic [NUM_ADDR_BITS:0]     credit_cnt;
  logic [CW-1:0]              credit_sum;

  logic                       pkt_valid;
  logic                       pkt_consumed;
  logic                       issue;
  logic                       wr_en;

  // Full/empty come straight from the registered count, keeping din_ack free
  // of any path from pkt_ready.
  assign fifo_full     = (fifo_count == (FIFO_DEPTH_BITS + 1)'(FIFO_DEPTH));
  assign fifo_nonempty = (fifo_count != '0);

  assign din_ack = din_vld & ~fifo_full & ~reset;
  assign wr_en   = din_ack;

  assign pkt_valid    = pkt_out[PACKET_BITS-1];
  assign pkt_consumed = pkt_valid & pkt_ready;
  // The output register is free when empty or being drained this cycle.
  assign issue = fifo_nonempty & (credit_cnt != '0) & (~pkt_valid | pkt_ready);

  // Issue and return land in the same update; issue only happens with
  // credit_cnt != 0, so the subtraction cannot underflow.
  always_comb begin
    credit_sum = CW'(credit_cnt) - CW'(issue);
    if (credit_ret_vld) begin
      credit_sum = credit_sum + CW'(credit_ret_num);
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk_user) begin
    if (wr_en) begin
      fifo_mem[wr_ptr] <= din_user;
    end
  end

  always_ff @(posedge clk_user or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + FIFO_DEPTH_BITS'(1);
      end
      if (issue) begin
        rd_ptr <= rd_ptr + FIFO_DEPTH_BITS'(1);
      end
      if (wr_en && !issue) begin
        fifo_count <= fifo_count + (FIFO_DEPTH_BITS + 1)'(1);
      end else if (!wr_en && issue) begin
        fifo_count <= fifo_count - (FIFO_DEPTH_BITS + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk_user or posedge reset) begin
    if (reset) begin
      pkt_out  <= '0;
      addr_cnt <= '0;
    end else begin
      if (issue) begin
        pkt_out  <= {1'b1, dest_leaf, dest_port, addr_cnt, fifo_mem[rd_ptr]};
        addr_cnt <= addr_cnt + NUM_ADDR_BITS'(1);
      end else if (pkt_consumed) begin
        // Only the valid bit drops; the stale fields are left in place.
        pkt_out[PACKET_BITS-1] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_user or posedge reset) begin
    if (reset) begin
      credit_cnt <= (NUM_ADDR_BITS + 1)'(CREDIT_MAX);
      credit_err <= 1'b0;
    end else begin
      if (credit_sum > CW'(CREDIT_MAX)) begin
        credit_cnt <= (NUM_ADDR_BITS + 1)'(CREDIT_MAX);
        credit_err <= 1'b1;
      end else begin
        credit_cnt <= credit_sum[NUM_ADDR_BITS:0];
      end
    end
  end

endmodule

// File: tb/tb_leaf_user2bft_packetizer.sv
module tb_leaf_user2bft_packetizer;

  logic        clk_user;
  logic        reset;
  logic [31:0] din_user;
  logic        din_vld;
  logic        din_ack;
  logic [4:0]  dest_leaf;
  logic [3:0]  dest_port;
  logic        credit_ret_vld;
  logic [7:0]  credit_ret_num;
  logic [48:0] pkt_out;
  logic        pkt_ready;
  logic        credit_err;

  int          n_checks;
  int          n_fail;

  logic [31:0] exp_q[$];
  logic [31:0] next_word;
  logic [6:0]  exp_addr;
  int          pkt_cnt;

  leaf_user2bft_packetizer dut (
    .clk_user       (clk_user),
    .reset          (reset),
    .din_user       (din_user),
    .din_vld        (din_vld),
    .din_ack        (din_ack),
    .dest_leaf      (dest_leaf),
    .dest_port      (dest_port),
    .credit_ret_vld (credit_ret_vld),
    .credit_ret_num (credit_ret_num),
    .pkt_out        (pkt_out),
    .pkt_ready      (pkt_ready),
    .credit_err     (credit_err)
  );

  // Clock / reset
  initial clk_user = 1'b0;
  always #5 clk_user = ~clk_user;

  // Leaves the bench at posedge+1 with reset released and scoreboard cleared.
  task automatic do_reset();
    reset          = 1'b1;
    din_vld        = 1'b0;
    pkt_ready      = 1'b0;
    credit_ret_vld = 1'b0;
    credit_ret_num = 8'd0;
    dest_leaf      = 5'd3;
    dest_port      = 4'd2;
    exp_q.delete();
    exp_addr = 7'd0;
    pkt_cnt  = 0;
    repeat (2) @(posedge clk_user);
    #1;
    reset = 1'b0;
  endtask

  // Driver + scoreboard for one cycle. Inputs change at posedge+1; acceptance
  // and consumption are observed at the negedge. din_user only advances when
  // the previous word was acked, so the user holds its word while stalled.
  task automatic cycle_step(input logic vld, input logic rdy,
                            input logic rv, input logic [7:0] rn);
    logic [31:0] exp_word;
    din_vld        = vld;
    pkt_ready      = rdy;
    credit_ret_vld = rv;
    credit_ret_num = rn;
    din_user       = next_word;
    @(negedge clk_user);
    if (din_ack) begin
      exp_q.push_back(din_user);
      next_word = next_word + 32'h0123_4567;
    end
    if (pkt_out[48] && pkt_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_pkt: got %h, expected no packet", pkt_out);
      end else begin
        exp_word = exp_q.pop_front();
        if (pkt_out[47:0] !== {dest_leaf, dest_port, exp_addr, exp_word}) begin
          n_fail++;
          $display("FAIL sb_packet: got %h, expected %h", pkt_out[47:0],
                   {dest_leaf, dest_port, exp_addr, exp_word});
        end
      end
      exp_addr = exp_addr + 7'd1;
      pkt_cnt++;
    end
    @(posedge clk_user);
    #1;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    din_vld = 1'b1;
    #1;
    n_checks++;
    if (pkt_out !== 49'd0) begin
      n_fail++;
      $display("FAIL reset_pkt_out: got %h, expected 0", pkt_out);
    end
    n_checks++;
    if (din_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_din_ack: got %b, expected 0", din_ack);
    end
    n_checks++;
    if (credit_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_credit_err: got %b, expected 0", credit_err);
    end
    do_reset();
  endtask

  task automatic test_first_packet();
    do_reset();
    din_vld  = 1'b1;
    din_user = 32'hA5A5_A5A5;
    #1;
    n_checks++;
    if (din_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL first_ack_cycle0: got %b, expected 1", din_ack);
    end
    @(posedge clk_user);
    #1;
    din_vld = 1'b0;
    #1;
    n_checks++;
    if (pkt_out[48] !== 1'b0) begin
      n_fail++;
      $display("FAIL first_not_valid_cycle1: got %b, expected 0", pkt_out[48]);
    end
    n_checks++;
    if (din_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL first_ack_no_vld: got %b, expected 0", din_ack);
    end
    @(posedge clk_user);
    #1;
    n_checks++;
    if (pkt_out !== 49'h1_1900_A5A5_A5A5) begin
      n_fail++;
      $display("FAIL first_pkt_cycle2: got %h, expected 11900a5a5a5a5", pkt_out);
    end
    pkt_ready = 1'b1;
    @(posedge clk_user);
    #1;
    n_checks++;
    if (pkt_out !== 49'h0_1900_A5A5_A5A5) begin
      n_fail++;
      $display("FAIL first_consumed: got %h, expected 01900a5a5a5a5", pkt_out);
    end
  endtask

  task automatic test_credit_exhaust();
    do_reset();
    for (int i = 0; i < 140; i++) cycle_step(1'b1, 1'b1, 1'b0, 8'd0);
    n_checks++;
    if (pkt_cnt !== 128) begin
      n_fail++;
      $display("FAIL exhaust_count: got %0d, expected 128", pkt_cnt);
    end
    n_checks++;
    if (din_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL exhaust_fifo_full: got din_ack=%b, expected 0", din_ack);
    end
    n_checks++;
    if (pkt_out[48] !== 1'b0) begin
      n_fail++;
      $display("FAIL exhaust_stalled: got valid=%b, expected 0", pkt_out[48]);
    end
    cycle_step(1'b1, 1'b1, 1'b1, 8'd5);
    for (int i = 0; i < 15; i++) cycle_step(1'b1, 1'b1, 1'b0, 8'd0);
    n_checks++;
    if (pkt_cnt !== 133 || exp_addr !== 7'd5) begin
      n_fail++;
      $display("FAIL return5_count: got %0d pkts next_addr %0d, expected 133 and 5",
               pkt_cnt, exp_addr);
    end
    n_checks++;
    if (din_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL return5_refill: got din_ack=%b, expected 0", din_ack);
    end
  endtask

  task automatic test_backpressure();
    logic [48:0] held;
    do_reset();
    for (int i = 0; i < 3; i++) cycle_step(1'b1, 1'b0, 1'b0, 8'd0);
    held = pkt_out;
    n_checks++;
    if (held[48] !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_valid: got %b, expected 1", held[48]);
    end
    for (int i = 0; i < 10; i++) begin
      cycle_step(1'b1, 1'b0, 1'b0, 8'd0);
      n_checks++;
      if (pkt_out !== held) begin
        n_fail++;
        $display("FAIL bp_stable: got %h, expected %h", pkt_out, held);
      end
    end
    n_checks++;
    if (din_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_ack_drop: got %b, expected 0", din_ack);
    end
    for (int i = 0; i < 8; i++) cycle_step(1'b0, 1'b1, 1'b0, 8'd0);
    n_checks++;
    if (pkt_cnt !== 5 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL bp_drain: got %0d pkts %0d left, expected 5 and 0",
               pkt_cnt, exp_q.size());
    end
  endtask

  task automatic test_credit_overflow();
    do_reset();
    cycle_step(1'b1, 1'b1, 1'b0, 8'd0);
    cycle_step(1'b1, 1'b1, 1'b0, 8'd0);
    // Credit is 127 here and the second word issues in this same cycle.
    cycle_step(1'b0, 1'b1, 1'b1, 8'd2);
    cycle_step(1'b0, 1'b1, 1'b0, 8'd0);
    n_checks++;
    if (credit_err !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_exact_128: got credit_err=%b, expected 0", credit_err);
    end
    cycle_step(1'b0, 1'b1, 1'b1, 8'd1);
    n_checks++;
    if (credit_err !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: got credit_err=%b, expected 1", credit_err);
    end
    for (int i = 0; i < 3; i++) cycle_step(1'b0, 1'b1, 1'b0, 8'd0);
    n_checks++;
    if (credit_err !== 1'b1 || pkt_cnt !== 2) begin
      n_fail++;
      $display("FAIL ovf_sticky: got credit_err=%b pkts=%0d, expected 1 and 2",
               credit_err, pkt_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) cycle_step(1'b1, 1'b0, 1'b0, 8'd0);
    n_checks++;
    if (pkt_out[48] !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre_valid: got %b, expected 1", pkt_out[48]);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (pkt_out !== 49'd0 || din_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_async_clear: got pkt=%h ack=%b, expected 0 and 0",
               pkt_out, din_ack);
    end
    do_reset();
    for (int i = 0; i < 2; i++) cycle_step(1'b1, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 6; i++) cycle_step(1'b0, 1'b1, 1'b0, 8'd0);
    n_checks++;
    if (pkt_cnt !== 2 || exp_addr !== 7'd2 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL mid_restart: got %0d pkts next_addr %0d, expected 2 and 2",
               pkt_cnt, exp_addr);
    end
  endtask

  task automatic test_random();
    int returned;
    int owed;
    int rn;
    logic rv;
    do_reset();
    returned = 0;
    for (int i = 0; i < 3000; i++) begin
      owed = pkt_cnt - returned;
      rv = (owed > 0) && ($urandom_range(0, 3) == 0);
      rn = 0;
      if (rv) rn = $urandom_range(1, (owed < 8) ? owed : 8);
      returned += rn;
      cycle_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rv, 8'(rn));
    end
    for (int i = 0; i < 300 && (exp_q.size() != 0 || pkt_cnt != returned); i++) begin
      owed = pkt_cnt - returned;
      rn = (owed > 255) ? 255 : owed;
      returned += rn;
      cycle_step(1'b0, 1'b1, (rn > 0), 8'(rn));
    end
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL rand_drain: got %0d words left, expected 0", exp_q.size());
    end
    n_checks++;
    if (credit_err !== 1'b0 || pkt_cnt < 200) begin
      n_fail++;
      $display("FAIL rand_health: got credit_err=%b pkts=%0d, expected 0 and >=200",
               credit_err, pkt_cnt);
    end
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    next_word      = 32'h1000_0001;
    din_user       = 32'd0;
    din_vld        = 1'b0;
    pkt_ready      = 1'b0;
    credit_ret_vld = 1'b0;
    credit_ret_num = 8'd0;
    dest_leaf      = 5'd3;
    dest_port      = 4'd2;
    reset          = 1'b1;
    test_reset();
    test_first_packet();
    test_credit_exhaust();
    test_backpressure();
    test_credit_overflow();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
